// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcodes, arbiter state encoding and helpers.
// Optional perf counters are enabled by defining ALU_ARB_PERF_EN.
package alu_arbiter_pkg;

  localparam int ALU_BITS    = 32;
  localparam int ALU_OP_BITS = 4;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLT = 4'd4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(
    input logic [15:0] v,
    input logic        en
  );
    if (en && v != CNT_MAX) return v + 16'd1;
    return v;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: y = op(in1, in2); SLT is signed.
// Ports: op, in1, in2 in; y out. Unknown opcodes pass in1 through.
import alu_arbiter_pkg::*;

module alu #(
  parameter int BITS    = 32,
  parameter int OP_BITS = 4
) (
  input  logic [OP_BITS-1:0] op,
  input  logic [BITS-1:0]    in1,
  input  logic [BITS-1:0]    in2,
  output logic [BITS-1:0]    y
);

  always_comb begin
    y = in1;
    case (op)
      OP_BITS'(ALU_ADD): y = in1 + in2;
      OP_BITS'(ALU_SUB): y = in1 - in2;
      OP_BITS'(ALU_AND): y = in1 & in2;
      OP_BITS'(ALU_OR):  y = in1 | in2;
      OP_BITS'(ALU_SLT):
        y = BITS'($signed(in1) < $signed(in2));
      default:           y = in1;
    endcase
  end

endmodule

// File: rtl/alu_rr_pick.sv
// Two-way round-robin picker.
// Ports: valid[1:0], last_grant in; grant[1:0] one-hot or zero out.
import alu_arbiter_pkg::*;

module alu_rr_pick (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // tie goes to whoever did not win last time
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between EX (req 0) and the address unit (req 1).
// Ports: req valid/ready/op/a/b per requester, rsp valid/ready,
// shared registered rsp_data. ALU_ARB_PERF_EN adds grant/stall counters.
import alu_arbiter_pkg::*;

module alu_arbiter #(
  parameter int BITS    = 32,
  parameter int OP_BITS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [OP_BITS-1:0] req_op0,
  input  logic [OP_BITS-1:0] req_op1,
  input  logic [BITS-1:0]    req_a0,
  input  logic [BITS-1:0]    req_a1,
  input  logic [BITS-1:0]    req_b0,
  input  logic [BITS-1:0]    req_b1,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
`ifdef ALU_ARB_PERF_EN
  output logic [15:0]        grant_cnt0,
  output logic [15:0]        grant_cnt1,
  output logic [15:0]        stall_cnt,
`endif
  output logic [BITS-1:0]    rsp_data
);

  arb_state_e         state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [BITS-1:0]    res_q, res_d;
  logic [OP_BITS-1:0] op_q, op_d;
  logic [BITS-1:0]    a_q, a_d;
  logic [BITS-1:0]    b_q, b_d;

  logic [1:0]         pick;
  logic               accept;
  logic               grant;
  logic               gidx;
  logic [OP_BITS-1:0] alu_op;
  logic [BITS-1:0]    alu_a;
  logic [BITS-1:0]    alu_b;
  logic [BITS-1:0]    alu_y;

  alu_rr_pick u_pick (
    .valid      (req_valid),
    .last_grant (last_q),
    .grant      (pick)
  );

  alu #(
    .BITS    (BITS),
    .OP_BITS (OP_BITS)
  ) u_alu (
    .op  (alu_op),
    .in1 (alu_a),
    .in2 (alu_b),
    .y   (alu_y)
  );

  // Draining the held result in the same cycle frees the slot.
  assign accept = reset_n &&
    (state_q == ARB_IDLE || rsp_ready[owner_q]);
  assign req_ready = accept ? pick : 2'b00;
  assign grant = |req_ready;
  assign gidx  = req_ready[1];

  // Without a grant the ALU sees the last granted operands.
  always_comb begin
    alu_op = op_q;
    alu_a  = a_q;
    alu_b  = b_q;
    if (grant) begin
      alu_op = gidx ? req_op1 : req_op0;
      alu_a  = gidx ? req_a1 : req_a0;
      alu_b  = gidx ? req_b1 : req_b0;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    res_d   = res_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    if (grant) begin
      state_d = ARB_HOLD;
      owner_d = gidx;
      last_d  = gidx;
      res_d   = alu_y;
      op_d    = alu_op;
      a_d     = alu_a;
      b_d     = alu_b;
    end else if (state_q == ARB_HOLD &&
                 rsp_ready[owner_q]) begin
      state_d = ARB_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      res_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      res_q   <= res_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  always_comb begin
    rsp_valid = 2'b00;
    if (state_q == ARB_HOLD)
      rsp_valid = owner_q ? 2'b10 : 2'b01;
  end

  assign rsp_data = res_q;

`ifdef ALU_ARB_PERF_EN
  logic [15:0] g0_q, g0_d;
  logic [15:0] g1_q, g1_d;
  logic [15:0] st_q, st_d;

  always_comb begin
    g0_d = sat_inc(g0_q, req_ready[0]);
    g1_d = sat_inc(g1_q, req_ready[1]);
    st_d = sat_inc(st_q, |(req_valid & ~req_ready));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      g0_q <= '0;
      g1_q <= '0;
      st_q <= '0;
    end else begin
      g0_q <= g0_d;
      g1_q <= g1_d;
      st_q <= st_d;
    end
  end

  assign grant_cnt0 = g0_q;
  assign grant_cnt1 = g1_q;
  assign stall_cnt  = st_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
// Perf-counter checks run when ALU_ARB_PERF_EN is defined.
import alu_arbiter_pkg::*;

module tb_alu_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req_op0, req_op1;
  logic [31:0] req_a0, req_a1;
  logic [31:0] req_b0, req_b1;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
`ifdef ALU_ARB_PERF_EN
  logic [15:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

  int total;
  int passed;
  int failed;

  alu_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op0   (req_op0),
    .req_op1   (req_op1),
    .req_a0    (req_a0),
    .req_a1    (req_a1),
    .req_b0    (req_b0),
    .req_b1    (req_b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
`ifdef ALU_ARB_PERF_EN
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1),
    .stall_cnt  (stall_cnt),
`endif
    .rsp_data  (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // advance one clock; return just after the falling edge
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    cyc();
    reset_n = 1'b1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    reset_n   = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    req_op0 = ALU_ADD; req_a0 = 0; req_b0 = 0;
    req_op1 = ALU_ADD; req_a1 = 0; req_b1 = 0;

    // reset
    @(negedge clk);
    #1 chk("rst_req_ready", 32'(req_ready), 32'h0);
    cyc();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);

    // single request
    reset_n   = 1'b1;
    req_valid = 2'b01;
    req_op0 = ALU_ADD; req_a0 = 5; req_b0 = 10;
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b00;
    #1;
    chk("single_valid", 32'(rsp_valid), 32'h1);
    chk("single_data", rsp_data, 32'd15);
    chk("single_noacc", 32'(req_ready), 32'h0);
    rsp_ready = 2'b01;
    cyc();
    chk("single_idle", 32'(rsp_valid), 32'h0);

    // contention with full drain
    do_reset();
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    req_op0 = ALU_SUB; req_a0 = 9; req_b0 = -32'sd9;
    req_op1 = ALU_OR;  req_a1 = 0; req_b1 = 1;
    #1 chk("cont_g0", 32'(req_ready), 32'h1);
    cyc();
    #1;
    chk("cont_v0", 32'(rsp_valid), 32'h1);
    chk("cont_d0", rsp_data, 32'd18);
    chk("cont_g1", 32'(req_ready), 32'h2);
    cyc();
    #1;
    chk("cont_v1", 32'(rsp_valid), 32'h2);
    chk("cont_d1", rsp_data, 32'd1);
    chk("cont_g2", 32'(req_ready), 32'h1);
    cyc();
    chk("cont_d2", rsp_data, 32'd18);

    // backpressure
    do_reset();
    req_valid = 2'b10;
    req_op1 = ALU_AND; req_a1 = 1; req_b1 = 1;
    #1 chk("bp_g1", 32'(req_ready), 32'h2);
    cyc();
    req_valid = 2'b11;
    req_op0 = ALU_ADD; req_a0 = 2; req_b0 = 3;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_valid", 32'(rsp_valid), 32'h2);
      chk("bp_data", rsp_data, 32'd1);
      chk("bp_ready", 32'(req_ready), 32'h0);
      cyc();
    end
    rsp_ready = 2'b01;
    #1 chk("bp_wrong_bit", 32'(req_ready), 32'h0);
    rsp_ready = 2'b10;
    #1 chk("bp_drain_g0", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 2'b00;
    rsp_ready = 2'b01;
    #1;
    chk("bp_v0", 32'(rsp_valid), 32'h1);
    chk("bp_d0", rsp_data, 32'd5);
    cyc();
    chk("bp_idle", 32'(rsp_valid), 32'h0);

    // wrap and signed compare, back-to-back
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    req_op0 = ALU_ADD; req_a0 = 32'hFFFF_FFFF; req_b0 = 1;
    cyc();
    chk("wrap_add", rsp_data, 32'h0);
    req_op0 = ALU_SLT; req_a0 = 1; req_b0 = 0;
    cyc();
    chk("slt_1_0", rsp_data, 32'h0);
    req_a0 = 0; req_b0 = 1;
    cyc();
    chk("slt_0_1", rsp_data, 32'h1);
    req_a0 = 0; req_b0 = 0;
    cyc();
    chk("slt_0_0", rsp_data, 32'h0);
    req_a0 = 32'hFFFF_FFFF; req_b0 = 1;
    cyc();
    chk("slt_m1_1", rsp_data, 32'h1);
    chk("b2b_valid", 32'(rsp_valid), 32'h1);

    // reset while holding
    req_op0 = ALU_ADD; req_a0 = 5; req_b0 = 10;
    rsp_ready = 2'b00;
    cyc();
    chk("mid_hold", 32'(rsp_valid), 32'h1);
    reset_n   = 1'b0;
    req_valid = 2'b00;
    cyc();
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_data", rsp_data, 32'h0);
    reset_n   = 1'b1;
    req_valid = 2'b11;
    req_op0 = ALU_ADD; req_a0 = 1; req_b0 = 1;
    req_op1 = ALU_ADD; req_a1 = 2; req_b1 = 2;
    #1 chk("mid_tie_g0", 32'(req_ready), 32'h1);
    cyc();
    chk("mid_tie_data", rsp_data, 32'd2);

`ifdef ALU_ARB_PERF_EN
    do_reset();
    chk("perf_rst_g0", 32'(grant_cnt0), 32'h0);
    chk("perf_rst_st", 32'(stall_cnt), 32'h0);
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    repeat (4) cyc();
    req_valid = 2'b01;
    cyc();
    req_valid = 2'b00;
    cyc();
    chk("perf_g0", 32'(grant_cnt0), 32'd3);
    chk("perf_g1", 32'(grant_cnt1), 32'd2);
    chk("perf_st", 32'(stall_cnt), 32'd4);
    do_reset();
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("perf_sat", 32'(grant_cnt0), 32'h0000_FFFF);
    req_valid = 2'b00;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
